// File: rtl/tile_map_responder_pkg.sv
// Shared tile ids, map geometry defaults and the address-width helper
// used by the tile map responder and its storage.
package tile_map_responder_pkg;

  localparam logic [15:0] RS_FLOOR = 16'h0000;
  localparam logic [15:0] RS_WALL  = 16'h0001;

  localparam int MAP_W_DEFAULT = 13;
  localparam int MAP_H_DEFAULT = 13;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_RESP
  } state_t;

endpackage

// File: rtl/tile_map_responder_ram.sv
// Tile storage: one write port and one synchronous read port; a read of the
// address being written in the same cycle returns the old contents.
module tile_ram #(
  parameter int DEPTH = 169,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tile_map_responder.sv
// Live tile map: initialises walls/floor, then answers position queries with a
// fixed two-edge latency while accepting tile updates.
module tile_map_responder
  import tile_map_responder_pkg::*;
#(
  parameter int          MAP_W      = MAP_W_DEFAULT,
  parameter int          MAP_H      = MAP_H_DEFAULT,
  parameter logic [15:0] WALL_TILE  = RS_WALL,
  parameter logic [15:0] FLOOR_TILE = RS_FLOOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        q_valid,
  input  logic [3:0]  q_x,
  input  logic [3:0]  q_y,
  output logic        q_ready,
  output logic        r_valid,
  output logic [15:0] r_tile_id,
  input  logic        w_en,
  input  logic [3:0]  w_x,
  input  logic [3:0]  w_y,
  input  logic [15:0] w_tile_id,
  output logic        init_busy
);

  localparam int DEPTH = MAP_W * MAP_H;
  localparam int AW    = addr_width(DEPTH);

  state_t        state;
  logic [3:0]    init_x, init_y;
  logic [3:0]    cap_x, cap_y;
  logic          cap_off;
  logic          fwd_hit;
  logic [15:0]   fwd_data;
  logic [AW-1:0] read_addr;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;

  logic q_on_map, w_on_map, init_border, init_last_x, init_last;

  function automatic logic [AW-1:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
    return AW'(int'(y) * MAP_W + int'(x));
  endfunction

  assign q_on_map    = (int'(q_x) < MAP_W) && (int'(q_y) < MAP_H);
  assign w_on_map    = (int'(w_x) < MAP_W) && (int'(w_y) < MAP_H);
  assign init_last_x = (int'(init_x) == MAP_W - 1);
  assign init_last   = init_last_x && (int'(init_y) == MAP_H - 1);
  assign init_border = (init_x == 4'd0) || init_last_x ||
                       (init_y == 4'd0) || (int'(init_y) == MAP_H - 1);

  // The init sweep owns the write port; user writes only land once it is done.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cell_addr(w_x, w_y);
    ram_wdata = w_tile_id;
    if (state == ST_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = cell_addr(init_x, init_y);
      ram_wdata = init_border ? WALL_TILE : FLOOR_TILE;
    end else begin
      ram_we = w_en && w_on_map;
    end
  end

  tile_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (16)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (state == ST_READ),
    .raddr (read_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      init_x    <= 4'd0;
      init_y    <= 4'd0;
      init_busy <= 1'b1;
      q_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_tile_id <= 16'h0000;
      cap_x     <= 4'd0;
      cap_y     <= 4'd0;
      cap_off   <= 1'b0;
      fwd_hit   <= 1'b0;
      fwd_data  <= 16'h0000;
      read_addr <= '0;
    end else begin
      r_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (init_last) begin
            state     <= ST_IDLE;
            init_busy <= 1'b0;
            q_ready   <= 1'b1;
          end else if (init_last_x) begin
            init_x <= 4'd0;
            init_y <= init_y + 4'd1;
          end else begin
            init_x <= init_x + 4'd1;
          end
        end
        ST_IDLE: begin
          if (q_valid) begin
            cap_x     <= q_x;
            cap_y     <= q_y;
            cap_off   <= !q_on_map;
            read_addr <= q_on_map ? cell_addr(q_x, q_y) : '0;
            q_ready   <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          // RAM returns old data on this edge, so a coincident write must bypass it.
          fwd_hit  <= w_en && !cap_off && (w_x == cap_x) && (w_y == cap_y);
          fwd_data <= w_tile_id;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          r_valid   <= 1'b1;
          r_tile_id <= cap_off ? WALL_TILE : (fwd_hit ? fwd_data : ram_rdata);
          q_ready   <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_map_responder.sv
// Directed bench for tile_map_responder: init timing, query latency, off-map
// handling, write forwarding, back-to-back queries and async reset.
module tb_tile_map_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        q_valid;
  logic [3:0]  q_x, q_y;
  logic        q_ready;
  logic        r_valid;
  logic [15:0] r_tile_id;
  logic        w_en;
  logic [3:0]  w_x, w_y;
  logic [15:0] w_tile_id;
  logic        init_busy;

  int checks = 0;
  int errors = 0;

  tile_map_responder dut (
    .clk       (clk),
    .rst       (rst),
    .q_valid   (q_valid),
    .q_x       (q_x),
    .q_y       (q_y),
    .q_ready   (q_ready),
    .r_valid   (r_valid),
    .r_tile_id (r_tile_id),
    .w_en      (w_en),
    .w_x       (w_x),
    .w_y       (w_y),
    .w_tile_id (w_tile_id),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts edges from reset release until init_busy drops; optionally pulses a write mid-init.
  task automatic wait_init(input string tag, input int pulse_at);
    int cycles;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      w_en      = (cycles == pulse_at);
      w_x       = 4'd1;
      w_y       = 4'd1;
      w_tile_id = 16'hDEAD;
    end while (init_busy && cycles < 400);
    w_en = 1'b0;
    chk({tag, "_init_cycles"}, cycles, 169);
    chk({tag, "_q_ready_after_init"}, q_ready, 1);
    $display("init %s: %0d cycles", tag, cycles);
  endtask

  // mode: 0 no write, 1 write in accept cycle, 2 write in READ, 3 write in RESP
  task automatic do_query(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input logic [15:0] exp, input int mode,
                          input logic [3:0] wx, input logic [3:0] wy, input logic [15:0] wd);
    w_x = wx; w_y = wy; w_tile_id = wd;
    q_valid = 1'b1; q_x = x; q_y = y;
    w_en = (mode == 1);
    chk({tag, "_q_ready_idle"}, q_ready, 1);
    @(negedge clk);
    q_valid = 1'b0;
    w_en = (mode == 2);
    chk({tag, "_q_ready_read"}, q_ready, 0);
    chk({tag, "_r_valid_n1"}, r_valid, 0);
    @(negedge clk);
    w_en = (mode == 3);
    chk({tag, "_r_valid_n2"}, r_valid, 0);
    @(negedge clk);
    w_en = 1'b0;
    chk({tag, "_r_valid_n3"}, r_valid, 1);
    chk({tag, "_tile"}, r_tile_id, exp);
    $display("query %s (%0d,%0d): tile %h expected %h", tag, x, y, r_tile_id, exp);
    @(negedge clk);
    chk({tag, "_r_valid_pulse_end"}, r_valid, 0);
  endtask

  task automatic do_write(input logic [3:0] x, input logic [3:0] y, input logic [15:0] d);
    w_en = 1'b1; w_x = x; w_y = y; w_tile_id = d;
    @(negedge clk);
    w_en = 1'b0;
    $display("write (%0d,%0d) = %h", x, y, d);
  endtask

  initial begin
    rst = 1'b1; q_valid = 1'b0; q_x = 4'd0; q_y = 4'd0;
    w_en = 1'b0; w_x = 4'd0; w_y = 4'd0; w_tile_id = 16'h0000;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_q_ready", q_ready, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_tile_id", r_tile_id, 16'h0000);
    rst = 1'b0;
    wait_init("first", 0);

    // Basic lookups
    do_query("q00", 4'd0, 4'd0, 16'h0001, 0, 4'd0, 4'd0, 16'h0);
    do_query("q611", 4'd6, 4'd11, 16'h0000, 0, 4'd0, 4'd0, 16'h0);
    do_query("q1212", 4'd12, 4'd12, 16'h0001, 0, 4'd0, 4'd0, 16'h0);

    // Off-map queries and a dropped off-map write that must not alias cell (1,1)
    do_query("q135", 4'd13, 4'd5, 16'h0001, 0, 4'd0, 4'd0, 16'h0);
    do_query("q415", 4'd4, 4'd15, 16'h0001, 0, 4'd0, 4'd0, 16'h0);
    do_write(4'd14, 4'd0, 16'h1234);
    do_query("q140", 4'd14, 4'd0, 16'h0001, 0, 4'd0, 4'd0, 16'h0);
    do_query("q11_alias", 4'd1, 4'd1, 16'h0000, 0, 4'd0, 4'd0, 16'h0);

    // Write forwarding
    do_query("fwd_same", 4'd6, 4'd10, 16'h00A5, 1, 4'd6, 4'd10, 16'h00A5);
    do_query("fwd_read", 4'd6, 4'd10, 16'h00B7, 2, 4'd6, 4'd10, 16'h00B7);
    do_query("resp_write", 4'd6, 4'd10, 16'h00B7, 3, 4'd6, 4'd10, 16'h00C9);
    do_query("after_resp_w", 4'd6, 4'd10, 16'h00C9, 0, 4'd0, 4'd0, 16'h0);
    do_query("read_other", 4'd3, 4'd3, 16'h0000, 2, 4'd4, 4'd3, 16'h0055);
    do_query("other_cell", 4'd4, 4'd3, 16'h0055, 0, 4'd0, 4'd0, 16'h0);

    // Continuous q_valid: accepts every third edge
    q_valid = 1'b1; q_x = 4'd12; q_y = 4'd0;
    chk("hold_q_ready_k0", q_ready, 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("hold_q_ready_k%0d", k), q_ready, (k % 3 == 0));
      chk($sformatf("hold_r_valid_k%0d", k), r_valid, (k % 3 == 0));
      if (k % 3 == 0) chk($sformatf("hold_tile_k%0d", k), r_tile_id, 16'h0001);
      $display("hold cycle %0d: q_ready=%0b r_valid=%0b", k, q_ready, r_valid);
    end
    q_valid = 1'b0;
    @(negedge clk);

    // Async reset midway through INIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midinit_init_busy", init_busy, 1);
    chk("midinit_q_ready", q_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("after_midinit", 0);

    // Async reset in READ
    q_valid = 1'b1; q_x = 4'd9; q_y = 4'd9;
    @(negedge clk);
    q_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midread_r_valid", r_valid, 0);
    chk("midread_init_busy", init_busy, 1);
    @(negedge clk);
    chk("midread_r_valid_later", r_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("after_midread", 0);

    // Async reset while a response is on the bus
    q_valid = 1'b1; q_x = 4'd0; q_y = 4'd5;
    @(negedge clk);
    q_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("resp_r_valid_before_rst", r_valid, 1);
    rst = 1'b1;
    #1;
    chk("resp_rst_r_valid", r_valid, 0);
    chk("resp_rst_r_tile_id", r_tile_id, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    wait_init("final", 100);

    // Map must be pristine: earlier writes cleared, INIT-time write ignored
    do_query("reinit_610", 4'd6, 4'd10, 16'h0000, 0, 4'd0, 4'd0, 16'h0);
    do_query("init_wen_11", 4'd1, 4'd1, 16'h0000, 0, 4'd0, 4'd0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
